// File: rtl/tone_player.sv
// tone_player: beat sequencer driving an external tone ROM, two square-wave
// tone channels (each with a sequential restoring divider that turns a tone
// frequency into a half-period in clock cycles) and a left-justified serial
// DAC stream.
// Optional feature macro: TONE_PLAYER_VOLUME_EN adds a 3-bit vol input and
// scales the square-wave amplitude to vol<<12; without it amplitude is 16'h2000.
//
// Control handshake: start and stop are single-cycle request pulses with no
// acknowledge. start is honoured only in IDLE and only when stop is low. stop
// is honoured only in PLAY and beats a simultaneous beat tick. busy mirrors
// the FSM state (1 = PLAY) and is the observable copy of that state.
module tone_player #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned BEAT_HZ  = 8,
    parameter int unsigned SONG_LEN = 10,
    parameter int unsigned SIL_TONE = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
`ifdef TONE_PLAYER_VOLUME_EN
    input  logic [2:0]  vol,
`endif
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [11:0] ibeatNum,
    input  logic [31:0] toneL,
    input  logic [31:0] toneR,
    output logic        busy,
    output logic        done,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    localparam int unsigned BEAT_CYC  = CLK_HZ / BEAT_HZ;
    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYC - 1);
    localparam logic [11:0] LAST_BEAT = 12'(SONG_LEN - 1);
    localparam logic [31:0] SIL       = 32'(SIL_TONE);
    localparam logic [31:0] DIVIDEND  = 32'(CLK_HZ);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t      state_q;
    logic [11:0] ibeat_q;
    logic [31:0] beat_cnt_q;
    logic        busy_q;
    logic        done_q;

    // Per-channel state; index 0 is left, index 1 is right.
    logic [31:0] tone_in       [2];
    logic [31:0] latched_d     [2];
    logic [31:0] latched_q     [2];
    logic [1:0]  silent;
    logic [1:0]  silent_d;
    logic [1:0]  div_busy_q;
    logic [5:0]  div_cnt_q     [2];
    logic [32:0] rem_q         [2];
    logic [31:0] quo_q         [2];
    logic [33:0] divisor_q     [2];
    logic [33:0] trial         [2];
    logic [31:0] half_period_q [2];
    logic [31:0] phase_cnt_q   [2];
    logic [1:0]  phase_q;
    logic [15:0] sample        [2];
    logic [15:0] amp;

    logic [8:0]  ser_cnt_q;
    logic [15:0] cap_l_q;
    logic [15:0] cap_r_q;
    logic [3:0]  bit_idx;

`ifdef TONE_PLAYER_VOLUME_EN
    assign amp = {1'b0, vol, 12'h000};
`else
    assign amp = 16'h2000;
`endif

    assign tone_in[0] = toneL;
    assign tone_in[1] = toneR;

    // Beat sequencer FSM with registered ibeatNum/busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ibeat_q    <= 12'd0;
            beat_cnt_q <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q    <= PLAY;
                        busy_q     <= 1'b1;
                        ibeat_q    <= 12'd0;
                        beat_cnt_q <= 32'd0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        ibeat_q    <= 12'd0;
                        beat_cnt_q <= 32'd0;
                    end else if (beat_cnt_q == BEAT_LAST) begin
                        beat_cnt_q <= 32'd0;
                        if (ibeat_q == LAST_BEAT) begin
                            ibeat_q <= 12'd0;
                            if (!loop_en) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            ibeat_q <= ibeat_q + 12'd1;
                        end
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ibeat_q <= 12'd0;
                end
            endcase
        end
    end

    assign ibeatNum = ibeat_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Per-channel tone selection, silence decode, divider trial and sample value.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            latched_d[c] = (state_q == PLAY) ? tone_in[c] : SIL;
            silent_d[c]  = (latched_d[c] == 32'd0) || (latched_d[c] >= SIL);
            silent[c]    = (latched_q[c] == 32'd0) || (latched_q[c] >= SIL);
            trial[c]     = {rem_q[c], quo_q[c][31]};
            if (silent[c]) begin
                sample[c] = 16'h0000;
            end else if (phase_q[c]) begin
                sample[c] = amp;
            end else begin
                sample[c] = ~amp + 16'd1;
            end
        end
    end

    // Tone latch and restoring divider: load on a tone change, 32 shift/subtract
    // steps, then publish the quotient as the new half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                latched_q[c]     <= SIL;
                div_cnt_q[c]     <= 6'd0;
                rem_q[c]         <= 33'd0;
                quo_q[c]         <= 32'd0;
                divisor_q[c]     <= 34'd0;
                half_period_q[c] <= 32'd0;
            end
            div_busy_q <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                latched_q[c] <= latched_d[c];
                if (latched_d[c] != latched_q[c]) begin
                    // A fresh tone always restarts the divide; silence just aborts it.
                    if (!silent_d[c]) begin
                        div_busy_q[c] <= 1'b1;
                        div_cnt_q[c]  <= 6'd0;
                        rem_q[c]      <= 33'd0;
                        quo_q[c]      <= DIVIDEND;
                        divisor_q[c]  <= {1'b0, latched_d[c], 1'b0};
                    end else begin
                        div_busy_q[c] <= 1'b0;
                    end
                end else if (div_busy_q[c]) begin
                    if (div_cnt_q[c] == 6'd32) begin
                        half_period_q[c] <= quo_q[c];
                        div_busy_q[c]    <= 1'b0;
                    end else begin
                        if (trial[c] >= divisor_q[c]) begin
                            rem_q[c] <= 33'(trial[c] - divisor_q[c]);
                            quo_q[c] <= {quo_q[c][30:0], 1'b1};
                        end else begin
                            rem_q[c] <= trial[c][32:0];
                            quo_q[c] <= {quo_q[c][30:0], 1'b0};
                        end
                        div_cnt_q[c] <= div_cnt_q[c] + 6'd1;
                    end
                end
            end
        end
    end

    // Square-wave phase generators; held at zero while silent or before the
    // first half-period is known.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                phase_cnt_q[c] <= 32'd0;
            end
            phase_q <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (silent[c] || (half_period_q[c] == 32'd0)) begin
                    phase_cnt_q[c] <= 32'd0;
                    phase_q[c]     <= 1'b0;
                end else if (phase_cnt_q[c] >= half_period_q[c] - 32'd1) begin
                    // >= rather than == so a shrinking half-period cannot overrun.
                    phase_cnt_q[c] <= 32'd0;
                    phase_q[c]     <= ~phase_q[c];
                end else begin
                    phase_cnt_q[c] <= phase_cnt_q[c] + 32'd1;
                end
            end
        end
    end

    // Serial frame counter; both samples are captured as the counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_cnt_q <= 9'd0;
            cap_l_q   <= 16'h0000;
            cap_r_q   <= 16'h0000;
        end else begin
            ser_cnt_q <= ser_cnt_q + 9'd1;
            if (ser_cnt_q == 9'd511) begin
                cap_l_q <= sample[0];
                cap_r_q <= sample[1];
            end
        end
    end

    assign bit_idx    = 4'd15 - ser_cnt_q[7:4];
    assign audio_mclk = ser_cnt_q[1];
    assign audio_sck  = ser_cnt_q[3];
    assign audio_lrck = ser_cnt_q[8];
    assign audio_sdin = ser_cnt_q[8] ? cap_r_q[bit_idx] : cap_l_q[bit_idx];

endmodule

// File: tb/tb_tone_player.sv
// Directed testbench for tone_player: small-clock instance for sequencing,
// divider, phase and serial behaviour, plus a default-clock instance for the
// 100 MHz half-period figure.
module tb_tone_player;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [31:0] toneL;
    logic [31:0] toneR;
    logic [11:0] ibeatNum;
    logic        busy;
    logic        done;
    logic        mclk;
    logic        lrck;
    logic        sck;
    logic        sdin;

    logic        start_h;
    logic [31:0] toneL_h;
    logic [11:0] ibeat_h;
    logic        busy_h;
    logic        done_h;
    logic        mclk_h;
    logic        lrck_h;
    logic        sck_h;
    logic        sdin_h;

    int          checks;
    int          failures;
    logic [8:0]  ser_m;

    tone_player #(
        .CLK_HZ   (1000),
        .BEAT_HZ  (10),
        .SONG_LEN (10),
        .SIL_TONE (50_000_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .ibeatNum   (ibeatNum),
        .toneL      (toneL),
        .toneR      (toneR),
        .busy       (busy),
        .done       (done),
        .audio_mclk (mclk),
        .audio_lrck (lrck),
        .audio_sck  (sck),
        .audio_sdin (sdin)
    );

    tone_player dut_hz (
        .clk        (clk),
        .rst        (rst),
        .start      (start_h),
        .stop       (1'b0),
        .loop_en    (1'b1),
        .ibeatNum   (ibeat_h),
        .toneL      (toneL_h),
        .toneR      (32'd0),
        .busy       (busy_h),
        .done       (done_h),
        .audio_mclk (mclk_h),
        .audio_lrck (lrck_h),
        .audio_sck  (sck_h),
        .audio_sdin (sdin_h)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame counter: zero under reset, free-running afterwards.
    always @(posedge clk) begin
        if (rst) ser_m <= 9'd0;
        else     ser_m <= ser_m + 9'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_song();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Collects one full serial frame starting at frame position 0.
    task automatic capture_frame(output logic [15:0] wl, output logic [15:0] wr,
                                 output int clk_err, output int r_ones, output int timeout);
        int n;
        n = 0; wl = '0; wr = '0; clk_err = 0; r_ones = 0; timeout = 0;
        while (ser_m != 9'd0 && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) timeout = 1;
        for (int i = 0; i < 512; i++) begin
            if (mclk !== ser_m[1] || sck !== ser_m[3] || lrck !== ser_m[8]) clk_err++;
            if (ser_m[8] && sdin !== 1'b0) r_ones++;
            if (ser_m[3:0] == 4'd0) begin
                if (ser_m[8]) wr[4'd15 - ser_m[7:4]] = sdin;
                else          wl[4'd15 - ser_m[7:4]] = sdin;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (ibeatNum !== 12'd0) begin failures++; $display("FAIL reset_beat: got %0d expected 0", ibeatNum); end
        checks++; if ({mclk, lrck, sck, sdin} !== 4'b0000) begin failures++; $display("FAIL reset_audio: got %b expected 0000", {mclk, lrck, sck, sdin}); end
        checks++; if (dut.half_period_q[0] !== 32'd0) begin failures++; $display("FAIL reset_hp: got %0d expected 0", dut.half_period_q[0]); end
        checks++; if (dut.phase_q !== 2'b00) begin failures++; $display("FAIL reset_phase: got %b expected 00", dut.phase_q); end
        checks++; if (busy_h !== 1'b0) begin failures++; $display("FAIL reset_busy_hz: got %0b expected 0", busy_h); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_play_once();
        logic [11:0] eb;
        loop_en = 1'b0;
        start_song();
        checks++; if (busy !== 1'b1 || ibeatNum !== 12'd0) begin failures++; $display("FAIL play_start: got busy=%0b beat=%0d expected busy=1 beat=0", busy, ibeatNum); end
        for (int k = 1; k <= 1001; k++) begin
            tick();
            eb = (k < 1000) ? 12'(k / 100) : 12'd0;
            checks++; if (ibeatNum !== eb) begin failures++; $display("FAIL play_beat k=%0d: got %0d expected %0d", k, ibeatNum, eb); end
            checks++; if (busy !== (k < 1000)) begin failures++; $display("FAIL play_busy k=%0d: got %0b expected %0b", k, busy, (k < 1000)); end
            checks++; if (done !== (k == 1000)) begin failures++; $display("FAIL play_done k=%0d: got %0b expected %0b", k, done, (k == 1000)); end
        end
    endtask

    task automatic test_loop();
        logic [11:0] eb;
        loop_en = 1'b1;
        start_song();
        for (int k = 1; k <= 1100; k++) begin
            tick();
            eb = 12'((k / 100) % 10);
            checks++; if (ibeatNum !== eb) begin failures++; $display("FAIL loop_beat k=%0d: got %0d expected %0d", k, ibeatNum, eb); end
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL loop_busy_done k=%0d: got %0b%0b expected 10", k, busy, done); end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (busy !== 1'b0 || ibeatNum !== 12'd0 || done !== 1'b0) begin failures++; $display("FAIL loop_stop: got busy=%0b beat=%0d done=%0b expected 0 0 0", busy, ibeatNum, done); end
        loop_en = 1'b0;
    endtask

    task automatic test_stop_on_tick();
        start_song();
        repeat (499) tick();
        checks++; if (ibeatNum !== 12'd4) begin failures++; $display("FAIL stop_pre_beat: got %0d expected 4", ibeatNum); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++; if (busy !== 1'b0 || ibeatNum !== 12'd0 || done !== 1'b0) begin failures++; $display("FAIL stop_tick: got busy=%0b beat=%0d done=%0b expected 0 0 0", busy, ibeatNum, done); end
        for (int k = 0; k < 200; k++) begin
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stop_after k=%0d: got done=%0b busy=%0b expected 0 0", k, done, busy); end
        end
    endtask

    task automatic test_start_ignored();
        start_song();
        repeat (50) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        checks++; if (ibeatNum !== 12'd1 || busy !== 1'b1) begin failures++; $display("FAIL restart_ignored: got beat=%0d busy=%0b expected 1 1", ibeatNum, busy); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_stop_idle: got busy=%0b expected 0", busy); end
        tick();
        checks++; if (busy !== 1'b0 || ibeatNum !== 12'd0) begin failures++; $display("FAIL start_stop_idle2: got busy=%0b beat=%0d expected 0 0", busy, ibeatNum); end
    endtask

    task automatic test_divider();
        logic prev;
        int   n;
        loop_en = 1'b1;
        toneL   = 32'd50;
        toneR   = 32'd50_000_000;
        start_song();
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 33) begin
                checks++; if (dut.half_period_q[0] !== 32'd0 || dut.div_busy_q[0] !== 1'b1) begin failures++; $display("FAIL div_pre: got hp=%0d busy=%0b expected 0 1", dut.half_period_q[0], dut.div_busy_q[0]); end
            end
            if (k == 34) begin
                checks++; if (dut.half_period_q[0] !== 32'd10 || dut.div_busy_q[0] !== 1'b0) begin failures++; $display("FAIL div_done: got hp=%0d busy=%0b expected 10 0", dut.half_period_q[0], dut.div_busy_q[0]); end
            end
        end
        toneL = 32'd20;
        repeat (12) tick();
        toneL = 32'd25;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 22 || k == 33) begin
                checks++; if (dut.half_period_q[0] !== 32'd10) begin failures++; $display("FAIL div_restart_hold k=%0d: got %0d expected 10", k, dut.half_period_q[0]); end
            end
            if (k == 34) begin
                checks++; if (dut.half_period_q[0] !== 32'd20) begin failures++; $display("FAIL div_restart: got %0d expected 20", dut.half_period_q[0]); end
            end
        end
        prev = dut.phase_q[0];
        n = 0;
        while (dut.phase_q[0] === prev && n < 100) begin tick(); n++; end
        checks++; if (n >= 100) begin failures++; $display("FAIL phase_first_toggle: got no toggle in %0d cycles expected toggle", n); end
        for (int t = 0; t < 2; t++) begin
            prev = dut.phase_q[0];
            n = 0;
            while (dut.phase_q[0] === prev && n < 100) begin tick(); n++; end
            checks++; if (n != 20) begin failures++; $display("FAIL phase_period %0d: got %0d expected 20", t, n); end
        end
    endtask

    task automatic test_serial();
        logic [15:0] wl;
        logic [15:0] wr;
        int          ce;
        int          ro;
        int          to;
        capture_frame(wl, wr, ce, ro, to);
        checks++; if (to != 0) begin failures++; $display("FAIL ser_align: got timeout expected frame start"); end
        checks++; if (ce != 0) begin failures++; $display("FAIL ser_clocks: got %0d errors expected 0", ce); end
        checks++; if (wl !== 16'h2000 && wl !== 16'hE000) begin failures++; $display("FAIL ser_left: got %h expected 2000 or e000", wl); end
        checks++; if (wr !== 16'h0000 || ro != 0) begin failures++; $display("FAIL ser_right_sil: got %h ones=%0d expected 0000 0", wr, ro); end
        toneR = 32'd0;
        capture_frame(wl, wr, ce, ro, to);
        capture_frame(wl, wr, ce, ro, to);
        checks++; if (wr !== 16'h0000 || ro != 0) begin failures++; $display("FAIL ser_right_zero: got %h ones=%0d expected 0000 0", wr, ro); end
        checks++; if (wl !== 16'h2000 && wl !== 16'hE000) begin failures++; $display("FAIL ser_left2: got %h expected 2000 or e000", wl); end
        toneL = 32'd0;
        capture_frame(wl, wr, ce, ro, to);
        capture_frame(wl, wr, ce, ro, to);
        checks++; if (wl !== 16'h0000) begin failures++; $display("FAIL ser_left_sil: got %h expected 0000", wl); end
    endtask

    task automatic test_reset_mid_play();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy: got %0b expected 1", busy); end
        toneL = 32'd40;
        repeat (5) tick();
        checks++; if (dut.div_busy_q[0] !== 1'b1) begin failures++; $display("FAIL midrst_div_run: got %0b expected 1", dut.div_busy_q[0]); end
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || ibeatNum !== 12'd0) begin failures++; $display("FAIL midrst_ctrl: got busy=%0b done=%0b beat=%0d expected 0 0 0", busy, done, ibeatNum); end
        checks++; if ({mclk, lrck, sck, sdin} !== 4'b0000) begin failures++; $display("FAIL midrst_audio: got %b expected 0000", {mclk, lrck, sck, sdin}); end
        checks++; if (dut.div_busy_q !== 2'b00 || dut.half_period_q[0] !== 32'd0) begin failures++; $display("FAIL midrst_div: got busy=%b hp=%0d expected 00 0", dut.div_busy_q, dut.half_period_q[0]); end
        rst     = 1'b0;
        toneL   = 32'd0;
        loop_en = 1'b0;
        tick();
    endtask

    task automatic test_hz();
        toneL_h = 32'd69;
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k == 33) begin
                checks++; if (dut_hz.half_period_q[0] !== 32'd0) begin failures++; $display("FAIL hz_pre: got %0d expected 0", dut_hz.half_period_q[0]); end
            end
            if (k == 34) begin
                checks++; if (dut_hz.half_period_q[0] !== 32'd724637) begin failures++; $display("FAIL hz_hp: got %0d expected 724637", dut_hz.half_period_q[0]); end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        loop_en  = 1'b0;
        toneL    = 32'd0;
        toneR    = 32'd0;
        start_h  = 1'b0;
        toneL_h  = 32'd0;
        test_reset();
        test_play_once();
        test_loop();
        test_stop_on_tick();
        test_start_ignored();
        test_divider();
        test_serial();
        test_reset_mid_play();
        test_hz();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
